// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, FSM state types and per-beat response helpers
// for the SRAM responder.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

   // Severity merge: DECERR > SLVERR > OKAY; EXOKAY ranks as OKAY.
   function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] w_a;
      logic [1:0] w_b;
      w_a = (a == AXI_RESP_EXOKAY) ? AXI_RESP_OKAY : a;
      w_b = (b == AXI_RESP_EXOKAY) ? AXI_RESP_OKAY : b;
      return (w_a > w_b) ? w_a : w_b;
   endfunction

   function automatic logic [1:0] beat_resp(input logic in_range, input logic [2:0] size,
                                            input logic [1:0] burst);
      if (!in_range)
         return AXI_RESP_DECERR;
      if (burst == AXI_BURST_WRAP || burst == 2'b11 || size > 3'd2)
         return AXI_RESP_SLVERR;
      return AXI_RESP_OKAY;
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst);
      if (burst == AXI_BURST_FIXED)
         return addr;
      return addr + (32'd1 << size);
   endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word SRAM split into four byte lanes: one asynchronous read port and one
// byte-enabled write port. Contents are never reset.
module axi_sram_mem #(
   parameter int DEPTH = 4096,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             i_clock,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic [31:0]      o_rd_data,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [3:0]       i_wstrb,
   input  logic [31:0]      i_wdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_lane [DEPTH];

         always_ff @(posedge i_clock) begin
            if (i_we && i_wstrb[gi])
               r_lane[i_wr_idx] <= i_wdata[gi*8 +: 8];
         end

         assign o_rd_data[gi*8 +: 8] = r_lane[i_rd_idx];
      end
   endgenerate

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 subordinate serving a word SRAM with independent read and write engines,
// INCR/FIXED bursts, byte strobes and a configurable read latency.
module axi_sram_responder
   import axi_pkg::*;
#(
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter int          DEPTH  = 4096,
   parameter int          RD_LAT = 1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [31:0] i_axi_araddr,
   input  logic        i_axi_arvalid,
   output logic        o_axi_arready,
   input  logic [3:0]  i_axi_arid,
   input  logic [7:0]  i_axi_arlen,
   input  logic [2:0]  i_axi_arsize,
   input  logic [1:0]  i_axi_arburst,
   output logic [31:0] o_axi_rdata,
   output logic [1:0]  o_axi_rresp,
   output logic [3:0]  o_axi_rid,
   output logic        o_axi_rlast,
   output logic        o_axi_rvalid,
   input  logic        i_axi_rready,
   input  logic [31:0] i_axi_awaddr,
   input  logic        i_axi_awvalid,
   output logic        o_axi_awready,
   input  logic [3:0]  i_axi_awid,
   input  logic [7:0]  i_axi_awlen,
   input  logic [2:0]  i_axi_awsize,
   input  logic [1:0]  i_axi_awburst,
   input  logic [31:0] i_axi_wdata,
   input  logic [3:0]  i_axi_wstrb,
   input  logic        i_axi_wlast,
   input  logic        i_axi_wvalid,
   output logic        o_axi_wready,
   output logic [1:0]  o_axi_bresp,
   output logic [3:0]  o_axi_bid,
   output logic        o_axi_bvalid,
   input  logic        i_axi_bready
);

   localparam int          IDX_W = $clog2(DEPTH);
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

   rd_state_t   r_rstate;
   logic [31:0] r_raddr;
   logic [3:0]  r_rid;
   logic [7:0]  r_rlen;
   logic [2:0]  r_rsize;
   logic [1:0]  r_rburst;
   logic [7:0]  r_rbeat;
   logic [15:0] r_rwait;
   logic        r_arready;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;
   logic        r_rlast;

   wr_state_t   r_wstate;
   logic [31:0] r_waddr;
   logic [3:0]  r_wid;
   logic [7:0]  r_wlen;
   logic [2:0]  r_wsize;
   logic [1:0]  r_wburst;
   logic [7:0]  r_wbeat;
   logic [1:0]  r_wacc;
   logic        r_awready;
   logic        r_wready;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic [3:0]  r_bid;

   logic [31:0] w_rd_addr;
   logic [2:0]  w_rd_size;
   logic [1:0]  w_rd_burst;
   logic [31:0] w_rd_off;
   logic [1:0]  w_rd_resp;
   logic [31:0] w_mem_rdata;
   logic [31:0] w_rd_word;

   logic [31:0] w_wr_off;
   logic [1:0]  w_wr_addr_resp;
   logic        w_wbeat_fire;
   logic        w_wlen_hit;
   logic [1:0]  w_wbeat_resp;
   logic        w_mem_we;

   // The single read port looks at whichever beat is about to be loaded into rdata.
   always_comb begin
      w_rd_addr  = r_raddr;
      w_rd_size  = r_rsize;
      w_rd_burst = r_rburst;
      case (r_rstate)
         R_IDLE: begin
            w_rd_addr  = i_axi_araddr;
            w_rd_size  = i_axi_arsize;
            w_rd_burst = i_axi_arburst;
         end
         R_DATA:  w_rd_addr = next_addr(r_raddr, r_rsize, r_rburst);
         default: ;
      endcase
   end

   assign w_rd_off  = w_rd_addr - BASE;
   assign w_rd_resp = beat_resp(w_rd_off < SPAN, w_rd_size, w_rd_burst);
   assign w_rd_word = (w_rd_resp == AXI_RESP_OKAY) ? w_mem_rdata : 32'd0;

   assign w_wr_off       = r_waddr - BASE;
   assign w_wr_addr_resp = beat_resp(w_wr_off < SPAN, r_wsize, r_wburst);
   assign w_wbeat_fire   = (r_wstate == W_DATA) && i_axi_wvalid && r_wready;
   assign w_wlen_hit     = (r_wbeat == r_wlen);
   assign w_wbeat_resp   = worst_resp(w_wr_addr_resp,
                                      (i_axi_wlast != w_wlen_hit) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
   assign w_mem_we       = w_wbeat_fire && (w_wr_addr_resp == AXI_RESP_OKAY);

   axi_sram_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
      .i_clock   (i_clock),
      .i_rd_idx  (w_rd_off[IDX_W+1:2]),
      .o_rd_data (w_mem_rdata),
      .i_we      (w_mem_we),
      .i_wr_idx  (w_wr_off[IDX_W+1:2]),
      .i_wstrb   (i_axi_wstrb),
      .i_wdata   (i_axi_wdata)
   );

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_rstate  <= R_IDLE;
         r_raddr   <= '0;
         r_rid     <= '0;
         r_rlen    <= '0;
         r_rsize   <= '0;
         r_rburst  <= '0;
         r_rbeat   <= '0;
         r_rwait   <= '0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= '0;
         r_rlast   <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               r_arready <= 1'b1;
               if (i_axi_arvalid && r_arready) begin
                  r_arready <= 1'b0;
                  r_raddr   <= i_axi_araddr;
                  r_rid     <= i_axi_arid;
                  r_rlen    <= i_axi_arlen;
                  r_rsize   <= i_axi_arsize;
                  r_rburst  <= i_axi_arburst;
                  r_rbeat   <= '0;
                  r_rwait   <= '0;
                  if (RD_LAT <= 1) begin
                     r_rstate <= R_DATA;
                     r_rvalid <= 1'b1;
                     r_rdata  <= w_rd_word;
                     r_rresp  <= w_rd_resp;
                     r_rlast  <= (i_axi_arlen == 8'd0);
                  end else begin
                     r_rstate <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               if (int'(r_rwait) >= RD_LAT - 2) begin
                  r_rstate <= R_DATA;
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_rd_word;
                  r_rresp  <= w_rd_resp;
                  r_rlast  <= (r_rlen == 8'd0);
               end else begin
                  r_rwait <= r_rwait + 16'd1;
               end
            end
            R_DATA: begin
               if (r_rvalid && i_axi_rready) begin
                  if (r_rlast) begin
                     r_rstate  <= R_IDLE;
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_rdata   <= '0;
                     r_rresp   <= '0;
                     r_arready <= 1'b1;
                  end else begin
                     r_raddr <= w_rd_addr;
                     r_rbeat <= r_rbeat + 8'd1;
                     r_rdata <= w_rd_word;
                     r_rresp <= w_rd_resp;
                     r_rlast <= (r_rbeat + 8'd1 == r_rlen);
                  end
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_wstate  <= W_IDLE;
         r_waddr   <= '0;
         r_wid     <= '0;
         r_wlen    <= '0;
         r_wsize   <= '0;
         r_wburst  <= '0;
         r_wbeat   <= '0;
         r_wacc    <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= '0;
         r_bid     <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               r_awready <= 1'b1;
               if (i_axi_awvalid && r_awready) begin
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_waddr   <= i_axi_awaddr;
                  r_wid     <= i_axi_awid;
                  r_wlen    <= i_axi_awlen;
                  r_wsize   <= i_axi_awsize;
                  r_wburst  <= i_axi_awburst;
                  r_wbeat   <= '0;
                  r_wacc    <= AXI_RESP_OKAY;
                  r_wstate  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_wbeat_fire) begin
                  // The burst ends on whichever comes first: wlast or the announced length.
                  if (i_axi_wlast || w_wlen_hit) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= worst_resp(r_wacc, w_wbeat_resp);
                     r_bid    <= r_wid;
                     r_wstate <= W_RESP;
                  end else begin
                     r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
                     r_wbeat <= r_wbeat + 8'd1;
                     r_wacc  <= worst_resp(r_wacc, w_wbeat_resp);
                  end
               end
            end
            W_RESP: begin
               if (i_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_bresp   <= '0;
                  r_awready <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   assign o_axi_arready = r_arready;
   assign o_axi_rvalid  = r_rvalid;
   assign o_axi_rdata   = r_rdata;
   assign o_axi_rresp   = r_rresp;
   assign o_axi_rid     = r_rid;
   assign o_axi_rlast   = r_rlast;
   assign o_axi_awready = r_awready;
   assign o_axi_wready  = r_wready;
   assign o_axi_bvalid  = r_bvalid;
   assign o_axi_bresp   = r_bresp;
   assign o_axi_bid     = r_bid;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: single-beat vector table plus
// hand-written burst, backpressure, error, concurrency and reset sequences.
module tb_axi_sram_responder;

   logic        clk = 1'b0;
   logic        i_reset = 1'b0;
   logic [31:0] i_axi_araddr = '0;
   logic        i_axi_arvalid = 1'b0;
   logic        o_axi_arready;
   logic [3:0]  i_axi_arid = '0;
   logic [7:0]  i_axi_arlen = '0;
   logic [2:0]  i_axi_arsize = '0;
   logic [1:0]  i_axi_arburst = '0;
   logic [31:0] o_axi_rdata;
   logic [1:0]  o_axi_rresp;
   logic [3:0]  o_axi_rid;
   logic        o_axi_rlast;
   logic        o_axi_rvalid;
   logic        i_axi_rready = 1'b0;
   logic [31:0] i_axi_awaddr = '0;
   logic        i_axi_awvalid = 1'b0;
   logic        o_axi_awready;
   logic [3:0]  i_axi_awid = '0;
   logic [7:0]  i_axi_awlen = '0;
   logic [2:0]  i_axi_awsize = '0;
   logic [1:0]  i_axi_awburst = '0;
   logic [31:0] i_axi_wdata = '0;
   logic [3:0]  i_axi_wstrb = '0;
   logic        i_axi_wlast = 1'b0;
   logic        i_axi_wvalid = 1'b0;
   logic        o_axi_wready;
   logic [1:0]  o_axi_bresp;
   logic [3:0]  o_axi_bid;
   logic        o_axi_bvalid;
   logic        i_axi_bready = 1'b0;

   axi_sram_responder #(.BASE(32'h8000_0000), .DEPTH(4096), .RD_LAT(1)) dut (
      .i_clock(clk), .i_reset(i_reset),
      .i_axi_araddr(i_axi_araddr), .i_axi_arvalid(i_axi_arvalid), .o_axi_arready(o_axi_arready),
      .i_axi_arid(i_axi_arid), .i_axi_arlen(i_axi_arlen), .i_axi_arsize(i_axi_arsize),
      .i_axi_arburst(i_axi_arburst),
      .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp), .o_axi_rid(o_axi_rid),
      .o_axi_rlast(o_axi_rlast), .o_axi_rvalid(o_axi_rvalid), .i_axi_rready(i_axi_rready),
      .i_axi_awaddr(i_axi_awaddr), .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready),
      .i_axi_awid(i_axi_awid), .i_axi_awlen(i_axi_awlen), .i_axi_awsize(i_axi_awsize),
      .i_axi_awburst(i_axi_awburst),
      .i_axi_wdata(i_axi_wdata), .i_axi_wstrb(i_axi_wstrb), .i_axi_wlast(i_axi_wlast),
      .i_axi_wvalid(i_axi_wvalid), .o_axi_wready(o_axi_wready),
      .o_axi_bresp(o_axi_bresp), .o_axi_bid(o_axi_bid), .o_axi_bvalid(o_axi_bvalid),
      .i_axi_bready(i_axi_bready)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] wd [256];
   logic [3:0]  ws [256];
   logic [31:0] rd_data [256];
   logic [1:0]  rd_resp [256];
   logic        rd_last [256];
   logic [3:0]  rd_id   [256];

   typedef struct {
      bit          do_write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  exp_bresp;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   vec_t vecs [11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL %s: got no handshake expected one within bound", name);
   endtask

   task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
      int t = 0;
      i_axi_awaddr = a; i_axi_awid = id; i_axi_awlen = len;
      i_axi_awsize = sz; i_axi_awburst = bu; i_axi_awvalid = 1'b1;
      while (!o_axi_awready && t < 50) begin step(); t++; end
      if (!o_axi_awready) timeout("aw_handshake");
      step();
      i_axi_awvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
      int t = 0;
      i_axi_araddr = a; i_axi_arid = id; i_axi_arlen = len;
      i_axi_arsize = sz; i_axi_arburst = bu; i_axi_arvalid = 1'b1;
      while (!o_axi_arready && t < 50) begin step(); t++; end
      if (!o_axi_arready) timeout("ar_handshake");
      step();
      i_axi_arvalid = 1'b0;
   endtask

   task automatic w_send(input int n, input int last_at);
      for (int b = 0; b < n; b++) begin
         int t = 0;
         i_axi_wdata = wd[b]; i_axi_wstrb = ws[b];
         i_axi_wlast = (b == last_at); i_axi_wvalid = 1'b1;
         while (!o_axi_wready && t < 50) begin step(); t++; end
         if (!o_axi_wready) timeout("w_handshake");
         step();
      end
      i_axi_wvalid = 1'b0;
      i_axi_wlast  = 1'b0;
   endtask

   task automatic b_get(output logic [1:0] resp, output logic [3:0] id);
      int t = 0;
      i_axi_bready = 1'b1;
      while (!o_axi_bvalid && t < 50) begin step(); t++; end
      if (!o_axi_bvalid) timeout("b_handshake");
      resp = o_axi_bresp;
      id   = o_axi_bid;
      step();
      i_axi_bready = 1'b0;
      $display("B resp=%0d id=%0d", resp, id);
   endtask

   // Collect n read beats; with toggle, rready alternates and stalled beats must hold still.
   task automatic r_collect(input int n, input bit toggle);
      int          got = 0;
      int          cyc = 0;
      bit          stalled = 1'b0;
      logic [31:0] held_data = '0;
      logic        held_last = 1'b0;
      while (got < n && cyc < 200) begin
         i_axi_rready = toggle ? (cyc[0] == 1'b0) : 1'b1;
         if (stalled && o_axi_rvalid) begin
            check("stall_rdata", o_axi_rdata, held_data);
            check("stall_rlast", {31'd0, o_axi_rlast}, {31'd0, held_last});
         end
         stalled = 1'b0;
         if (o_axi_rvalid && i_axi_rready) begin
            rd_data[got] = o_axi_rdata; rd_resp[got] = o_axi_rresp;
            rd_last[got] = o_axi_rlast; rd_id[got] = o_axi_rid;
            $display("R beat %0d data=%h resp=%0d last=%0d id=%0d", got, o_axi_rdata,
                     o_axi_rresp, o_axi_rlast, o_axi_rid);
            got++;
         end else if (o_axi_rvalid) begin
            stalled = 1'b1; held_data = o_axi_rdata; held_last = o_axi_rlast;
         end
         step();
         cyc++;
      end
      i_axi_rready = 1'b0;
      if (got < n) timeout("r_beats");
   endtask

   initial begin
      logic [1:0]  bresp;
      logic [3:0]  bid;
      logic [31:0] exp4 [4];
      int          lat;

      vecs[0]  = '{1'b1, 32'h8000_0000, 3'd2, 2'b01, 32'h1122_3344, 4'hF, 2'd0, 32'h1122_3344, 2'd0};
      vecs[1]  = '{1'b1, 32'h8000_0000, 3'd2, 2'b01, 32'hAABB_CCDD, 4'h5, 2'd0, 32'h11BB_33DD, 2'd0};
      vecs[2]  = '{1'b1, 32'h8000_3FFC, 3'd2, 2'b01, 32'hCAFE_F00D, 4'hF, 2'd0, 32'hCAFE_F00D, 2'd0};
      vecs[3]  = '{1'b1, 32'h8000_4000, 3'd2, 2'b01, 32'h1234_5678, 4'hF, 2'd3, 32'h0000_0000, 2'd3};
      vecs[4]  = '{1'b1, 32'h7FFF_FFFC, 3'd2, 2'b01, 32'h1234_5678, 4'hF, 2'd3, 32'h0000_0000, 2'd3};
      vecs[5]  = '{1'b1, 32'h8000_0020, 3'd3, 2'b01, 32'h1234_5678, 4'hF, 2'd2, 32'h0000_0000, 2'd2};
      vecs[6]  = '{1'b1, 32'h8000_0024, 3'd2, 2'b01, 32'h5566_7788, 4'hF, 2'd0, 32'h5566_7788, 2'd0};
      vecs[7]  = '{1'b1, 32'h8000_0024, 3'd2, 2'b10, 32'h9999_9999, 4'hF, 2'd2, 32'h0000_0000, 2'd2};
      vecs[8]  = '{1'b0, 32'h8000_0024, 3'd2, 2'b01, 32'h0000_0000, 4'hF, 2'd0, 32'h5566_7788, 2'd0};
      vecs[9]  = '{1'b1, 32'h8000_0030, 3'd2, 2'b00, 32'h0BAD_C0DE, 4'hF, 2'd0, 32'h0BAD_C0DE, 2'd0};
      vecs[10] = '{1'b1, 32'h8000_0034, 3'd2, 2'b11, 32'h1234_5678, 4'hF, 2'd2, 32'h0000_0000, 2'd2};

      // Reset: every output low while held, ready lines rise on the first edge after release.
      #12;
      check("reset_ctrl", {20'd0, o_axi_arready, o_axi_rvalid, o_axi_rlast, o_axi_rresp,
                           o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_bresp},
            32'd0);
      check("reset_rdata", o_axi_rdata, 32'd0);
      @(negedge clk);
      i_reset = 1'b1;
      step();
      check("post_reset_arready", {31'd0, o_axi_arready}, 32'd1);
      check("post_reset_awready", {31'd0, o_axi_awready}, 32'd1);

      // Single-beat vector table: write then read back with the same size/burst.
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].do_write) begin
            wd[0] = vecs[i].wdata; ws[0] = vecs[i].wstrb;
            aw_send(vecs[i].addr, 4'(i), 8'd0, vecs[i].size, vecs[i].burst);
            w_send(1, 0);
            b_get(bresp, bid);
            check($sformatf("vec%0d_bresp", i), {30'd0, bresp}, {30'd0, vecs[i].exp_bresp});
            check($sformatf("vec%0d_bid", i), {28'd0, bid}, 32'(i));
         end
         ar_send(vecs[i].addr, 4'(i + 1), 8'd0, vecs[i].size, vecs[i].burst);
         r_collect(1, 1'b0);
         check($sformatf("vec%0d_rdata", i), rd_data[0], vecs[i].exp_rdata);
         check($sformatf("vec%0d_rresp", i), {30'd0, rd_resp[0]}, {30'd0, vecs[i].exp_rresp});
         check($sformatf("vec%0d_rlast", i), {31'd0, rd_last[0]}, 32'd1);
      end

      // Single read of word 4: latency, id echo, data.
      wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
      aw_send(32'h8000_0010, 4'h1, 8'd0, 3'd2, 2'b01);
      w_send(1, 0);
      b_get(bresp, bid);
      ar_send(32'h8000_0010, 4'h3, 8'd0, 3'd2, 2'b01);
      lat = 1;
      while (!o_axi_rvalid && lat < 20) begin step(); lat++; end
      check("t1_latency", 32'(lat), 32'd1);
      r_collect(1, 1'b0);
      check("t1_rdata", rd_data[0], 32'hDEAD_BEEF);
      check("t1_rid", {28'd0, rd_id[0]}, 32'h3);
      check("t1_rresp", {30'd0, rd_resp[0]}, 32'd0);

      // INCR len=3 burst, then partial-strobe overwrite of word 0x41 only.
      for (int b = 0; b < 4; b++) begin wd[b] = 32'hA0A0_A0A0 + 32'(b) * 32'h0101_0101; ws[b] = 4'hF; end
      aw_send(32'h8000_0100, 4'h4, 8'd3, 3'd2, 2'b01);
      w_send(4, 3);
      b_get(bresp, bid);
      check("t2_bresp_a", {30'd0, bresp}, 32'd0);
      for (int b = 0; b < 4; b++) begin wd[b] = 32'hB0B0_B0B0 + 32'(b) * 32'h0101_0101; ws[b] = 4'h0; end
      ws[1] = 4'b0101;
      aw_send(32'h8000_0100, 4'h5, 8'd3, 3'd2, 2'b01);
      w_send(4, 3);
      b_get(bresp, bid);
      check("t2_bresp_b", {30'd0, bresp}, 32'd0);
      exp4[0] = 32'hA0A0_A0A0; exp4[1] = 32'hA1B1_A1B1; exp4[2] = 32'hA2A2_A2A2; exp4[3] = 32'hA3A3_A3A3;
      ar_send(32'h8000_0100, 4'h6, 8'd3, 3'd2, 2'b01);
      r_collect(4, 1'b0);
      for (int b = 0; b < 4; b++) begin
         check($sformatf("t2_rdata%0d", b), rd_data[b], exp4[b]);
         check($sformatf("t2_rlast%0d", b), {31'd0, rd_last[b]}, (b == 3) ? 32'd1 : 32'd0);
      end

      // Eight-beat read with rready toggling.
      for (int b = 0; b < 8; b++) begin wd[b] = 32'h3000_0000 + 32'(b) * 32'h0101_0101; ws[b] = 4'hF; end
      aw_send(32'h8000_0200, 4'h7, 8'd7, 3'd2, 2'b01);
      w_send(8, 7);
      b_get(bresp, bid);
      ar_send(32'h8000_0200, 4'h8, 8'd7, 3'd2, 2'b01);
      r_collect(8, 1'b1);
      for (int b = 0; b < 8; b++) begin
         check($sformatf("t3_rdata%0d", b), rd_data[b], 32'h3000_0000 + 32'(b) * 32'h0101_0101);
         check($sformatf("t3_rlast%0d", b), {31'd0, rd_last[b]}, (b == 7) ? 32'd1 : 32'd0);
      end

      // Early wlast on beat 1 of len=3: B follows that beat directly.
      for (int b = 0; b < 4; b++) begin wd[b] = 32'h4444_0000 + 32'(b); ws[b] = 4'hF; end
      aw_send(32'h8000_0300, 4'h9, 8'd3, 3'd2, 2'b01);
      w_send(2, 1);
      check("t4_wready_after", {31'd0, o_axi_wready}, 32'd0);
      check("t4_bvalid_after", {31'd0, o_axi_bvalid}, 32'd1);
      b_get(bresp, bid);
      check("t4_early_bresp", {30'd0, bresp}, 32'd2);
      check("t4_early_bid", {28'd0, bid}, 32'h9);
      // Missing wlast on the final beat.
      aw_send(32'h8000_0308, 4'hA, 8'd1, 3'd2, 2'b01);
      w_send(2, -1);
      b_get(bresp, bid);
      check("t4_nolast_bresp", {30'd0, bresp}, 32'd2);

      // Read beat and write to the same word on the same edge.
      wd[0] = 32'h1111_1111; ws[0] = 4'hF;
      aw_send(32'h8000_0400, 4'h1, 8'd0, 3'd2, 2'b01);
      w_send(1, 0);
      b_get(bresp, bid);
      aw_send(32'h8000_0400, 4'h2, 8'd0, 3'd2, 2'b01);
      i_axi_wdata = 32'h2222_2222; i_axi_wstrb = 4'hF; i_axi_wlast = 1'b1; i_axi_wvalid = 1'b1;
      i_axi_araddr = 32'h8000_0400; i_axi_arid = 4'hB; i_axi_arlen = 8'd0;
      i_axi_arsize = 3'd2; i_axi_arburst = 2'b01; i_axi_arvalid = 1'b1;
      check("t5_both_ready", {30'd0, o_axi_arready, o_axi_wready}, 32'd3);
      step();
      i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0; i_axi_arvalid = 1'b0;
      r_collect(1, 1'b0);
      check("t5_old_value", rd_data[0], 32'h1111_1111);
      b_get(bresp, bid);
      ar_send(32'h8000_0400, 4'hC, 8'd0, 3'd2, 2'b01);
      r_collect(1, 1'b0);
      check("t5_new_value", rd_data[0], 32'h2222_2222);

      // Reset during beat 2 of a 4-beat read.
      for (int b = 0; b < 4; b++) begin wd[b] = 32'h5500_0000 + 32'(b); ws[b] = 4'hF; end
      aw_send(32'h8000_0500, 4'hD, 8'd3, 3'd2, 2'b01);
      w_send(4, 3);
      b_get(bresp, bid);
      ar_send(32'h8000_0500, 4'hE, 8'd3, 3'd2, 2'b01);
      r_collect(2, 1'b0);
      check("t6_beat2_pending", {31'd0, o_axi_rvalid}, 32'd1);
      #2 i_reset = 1'b0;
      #1;
      check("t6_reset_ctrl", {16'd0, o_axi_arready, o_axi_rvalid, o_axi_rlast, o_axi_rresp,
                              o_axi_rid, o_axi_awready, o_axi_wready, o_axi_bvalid,
                              o_axi_bresp}, 32'd0);
      check("t6_reset_rdata", o_axi_rdata, 32'd0);
      @(negedge clk);
      i_reset = 1'b1;
      step();
      check("t6_arready", {31'd0, o_axi_arready}, 32'd1);
      ar_send(32'h8000_0504, 4'hF, 8'd0, 3'd2, 2'b01);
      r_collect(1, 1'b0);
      check("t6_retained", rd_data[0], 32'h5500_0001);
      check("t6_rid", {28'd0, rd_id[0]}, 32'hF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200us");
      $fatal(1, "bench timeout");
   end

endmodule
